// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS core: word width, memory
// controller state encoding and the opcodes decoded by the control FSM.
package mips_pkg;

    localparam int unsigned WORD_W = 32;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        RD_WAIT = 1'b1
    } mem_state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

endpackage

// File: rtl/mem_ctrl_if.sv
// Datapath-to-memory access bus: request side (master) and the
// memory controller side (slave).
interface mem_ctrl_if;
    import mips_pkg::*;

    logic              req;
    logic              we;
    logic [WORD_W-1:0] addr;
    logic [WORD_W-1:0] wdata;
    logic [WORD_W-1:0] rdata;
    logic              ready;
    logic              busy;
    logic              misalign;

    modport master (
        output req, we, addr, wdata,
        input  rdata, ready, busy, misalign
    );

    modport slave (
        input  req, we, addr, wdata,
        output rdata, ready, busy, misalign
    );

endinterface

// File: rtl/mem_array.sv
// DEPTH x 32 storage: synchronous write, combinational read, no reset.
module mem_array
    import mips_pkg::*;
#(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/mem_ctrl.sv
// Unified instruction/data memory controller: single-cycle writes, reads
// after RD_LAT cycles. MEM_ALIGN_CHECK_EN enables misaligned-access trapping.
module mem_ctrl
    import mips_pkg::*;
#(
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned RD_LAT = 3
) (
    input logic       clk,
    input logic       rst,
    mem_ctrl_if.slave bus
);

    localparam int unsigned AW       = $clog2(DEPTH);
    localparam logic [3:0]  CNT_INIT = 4'(RD_LAT - 1);

    mem_state_t        state;
    logic [3:0]        cnt;
    logic [AW-1:0]     idx_in;
    logic [AW-1:0]     idx_q;
    logic [AW-1:0]     raddr;
    logic [WORD_W-1:0] arr_rdata;
    logic [WORD_W-1:0] rdata_q;
    logic              ready_q;
    logic              mis_q;
    logic              rd_mis_q;
    logic              mis_in;
    logic              accept;
    logic              arr_we;
    logic              unused_addr;

    assign idx_in      = bus.addr[2 +: AW];
    assign accept      = (state == IDLE) && bus.req;
    assign unused_addr = ^{bus.addr[WORD_W-1:AW+2], bus.addr[1:0]};

`ifdef MEM_ALIGN_CHECK_EN
    assign mis_in = |bus.addr[1:0];
`else
    assign mis_in = 1'b0;
`endif

    assign arr_we = accept && bus.we && !mis_in;
    // Single-cycle reads use the live address; longer ones use the latched index.
    assign raddr  = (RD_LAT == 1) ? idx_in : idx_q;

    mem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .waddr (idx_in),
        .wdata (bus.wdata),
        .raddr (raddr),
        .rdata (arr_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            idx_q    <= '0;
            rdata_q  <= '0;
            ready_q  <= 1'b0;
            mis_q    <= 1'b0;
            rd_mis_q <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            mis_q   <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (bus.we) begin
                            ready_q <= 1'b1;
                            mis_q   <= mis_in;
                        end else begin
                            idx_q    <= idx_in;
                            cnt      <= CNT_INIT;
                            rd_mis_q <= mis_in;
                            if (RD_LAT == 1) begin
                                rdata_q <= mis_in ? '0 : arr_rdata;
                                ready_q <= 1'b1;
                                mis_q   <= mis_in;
                            end else begin
                                state <= RD_WAIT;
                            end
                        end
                    end
                end
                RD_WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        rdata_q <= rd_mis_q ? '0 : arr_rdata;
                        ready_q <= 1'b1;
                        mis_q   <= rd_mis_q;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.rdata    = rdata_q;
    assign bus.ready    = ready_q;
    assign bus.misalign = mis_q;
    assign bus.busy     = (state == RD_WAIT);

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: a RD_LAT=3/DEPTH=256 instance and a
// RD_LAT=1/DEPTH=64 instance, checked by per-instance expectation queues.
module tb_mem_ctrl;

`ifdef MEM_ALIGN_CHECK_EN
    localparam bit ALN = 1'b1;
`else
    localparam bit ALN = 1'b0;
`endif

    typedef struct {
        logic        rd;
        logic [31:0] data;
        logic        mis;
        int unsigned cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        sel = 1'b0;
    int unsigned cyc = 0;
    int unsigned vectors = 0;
    int unsigned miscompares = 0;
    exp_t        q0[$];
    exp_t        q1[$];

    mem_ctrl_if b0 ();
    mem_ctrl_if b1 ();

    assign b0.req   = req && !sel;
    assign b0.we    = we;
    assign b0.addr  = addr;
    assign b0.wdata = wdata;
    assign b1.req   = req && sel;
    assign b1.we    = we;
    assign b1.addr  = addr;
    assign b1.wdata = wdata;

    mem_ctrl #(.DEPTH(256), .RD_LAT(3)) dut (.clk(clk), .rst(rst), .bus(b0));
    mem_ctrl #(.DEPTH(64),  .RD_LAT(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        vectors++;
        if (act !== exp_v) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp_v);
        end
    endtask

    task automatic mon(input int unsigned d, input logic rdy, input logic mis, input logic [31:0] rd);
        exp_t e;
        if (mis && !rdy) begin
            vectors++;
            miscompares++;
            $display("FAIL dut%0d misalign_without_ready at cycle %0d", d, cyc);
        end
        if (!rdy) return;
        if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
            vectors++;
            miscompares++;
            $display("FAIL dut%0d unexpected_ready at cycle %0d", d, cyc);
            return;
        end
        e = (d == 0) ? q0.pop_front() : q1.pop_front();
        chk($sformatf("dut%0d ready_cycle", d), cyc, e.cyc);
        chk($sformatf("dut%0d misalign", d), {31'b0, mis}, {31'b0, e.mis});
        if (e.rd) chk($sformatf("dut%0d rdata", d), rd, e.data);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            mon(0, b0.ready, b0.misalign, b0.rdata);
            mon(1, b1.ready, b1.misalign, b1.rdata);
        end
    end

    function automatic logic cur_ready();
        return sel ? b1.ready : b0.ready;
    endfunction

    // Called at a negedge with the selected DUT idle; returns at the next negedge.
    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] exp_d, input logic exp_m);
        exp_t e;
        int unsigned lat;
        lat   = sel ? 1 : 3;
        req   = 1'b1;
        we    = w;
        addr  = a;
        wdata = d;
        @(posedge clk);
        #1;
        e.rd   = !w;
        e.data = exp_d;
        e.mis  = exp_m;
        e.cyc  = cyc + (w ? 0 : lat - 1);
        if (sel) q1.push_back(e);
        else q0.push_back(e);
        @(negedge clk);
        req   = 1'b0;
        we    = 1'b1;
        addr  = 32'hFFFF_FFFF;
        wdata = 32'hFFFF_FFFF;
    endtask

    task automatic wait_ready();
        int unsigned n = 0;
        while (!cur_ready() && n < 40) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (!cur_ready()) begin
            miscompares++;
            $display("FAIL ready_timeout: got no ready after %0d cycles, required ready", n);
        end
    endtask

    initial begin
        #3;
        chk("reset rdata", b0.rdata, 32'h0);
        chk("reset ready", {31'b0, b0.ready}, 32'h0);
        chk("reset busy", {31'b0, b0.busy}, 32'h0);
        chk("reset misalign", {31'b0, b0.misalign}, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Async reset while ready is high clears it at once; array survives.
        issue(1'b1, 32'h10, 32'hDEAD_BEEF, '0, 1'b0);
        chk("ready before reset", {31'b0, b0.ready}, 32'h1);
        #2 rst = 1'b1;
        #1 chk("ready async clear", {31'b0, b0.ready}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        issue(1'b0, 32'h10, '0, 32'hDEAD_BEEF, 1'b0);
        wait_ready();

        // Back-to-back write then read, no idle gap.
        issue(1'b1, 32'h0, 32'h1111_1111, '0, 1'b0);
        issue(1'b0, 32'h0, '0, 32'h1111_1111, 1'b0);
        wait_ready();

        // Request while busy is dropped.
        issue(1'b1, 32'h8, 32'h2222_2222, '0, 1'b0);
        issue(1'b1, 32'h4, 32'h4444_4444, '0, 1'b0);
        issue(1'b0, 32'h4, '0, 32'h4444_4444, 1'b0);
        chk("busy during read", {31'b0, b0.busy}, 32'h1);
        req = 1'b1; we = 1'b1; addr = 32'h8; wdata = 32'h0BAD_0BAD;
        @(negedge clk);
        req = 1'b0;
        wait_ready();
        issue(1'b0, 32'h8, '0, 32'h2222_2222, 1'b0);
        wait_ready();

        // Address wrap and top word.
        issue(1'b1, 32'h400, 32'hA5A5_A5A5, '0, 1'b0);
        issue(1'b0, 32'h000, '0, 32'hA5A5_A5A5, 1'b0);
        wait_ready();
        issue(1'b0, 32'hFFFF_FC10, '0, 32'hDEAD_BEEF, 1'b0);
        wait_ready();
        issue(1'b1, 32'h3FC, 32'h0F0F_0F0F, '0, 1'b0);
        issue(1'b0, 32'h3FC, '0, 32'h0F0F_0F0F, 1'b0);
        wait_ready();

        // Abort a read with reset in cycle c+2.
        issue(1'b0, 32'h10, '0, 32'hDEAD_BEEF, 1'b0);
        @(posedge clk);
        #2 rst = 1'b1;
        q0.delete();
        #1;
        chk("abort rdata", b0.rdata, 32'h0);
        chk("abort busy", {31'b0, b0.busy}, 32'h0);
        chk("abort ready", {31'b0, b0.ready}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("abort rdata held", b0.rdata, 32'h0);
        issue(1'b0, 32'h3FC, '0, 32'h0F0F_0F0F, 1'b0);
        wait_ready();

        // RD_LAT=1 instance: single-cycle reads and alignment handling.
        sel = 1'b1;
        issue(1'b1, 32'h20, 32'hCAFE_F00D, '0, 1'b0);
        issue(1'b1, 32'h22, 32'h1234_5678, '0, ALN);
        issue(1'b0, 32'h20, '0, ALN ? 32'hCAFE_F00D : 32'h1234_5678, 1'b0);
        wait_ready();
        issue(1'b0, 32'h23, '0, ALN ? 32'h0 : 32'h1234_5678, ALN);
        wait_ready();
        issue(1'b0, 32'h120, '0, ALN ? 32'hCAFE_F00D : 32'h1234_5678, 1'b0);
        wait_ready();

        repeat (6) @(negedge clk);
        chk("dut0 pending", q0.size(), 32'h0);
        chk("dut1 pending", q1.size(), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
